// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the HI/LO registers and MTHI/MTLO writes.
// Each arithmetic op takes WIDTH+1 cycles: WIDTH shift-add or shift-subtract iterations, then one sign-fixup cycle.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               neg_p_q, neg_p_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial, div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_signed = ~op_i[0];
    assign a_abs     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    // Multiply: the multiplier shifts out LSB first while the accumulator shifts right.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});

    // Divide: the dividend shifts out of a_q MSB first; the top bit of the trial difference is the borrow.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign div_rem   = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];

    assign prod_fix  = neg_p_q ? -acc_q : acc_q;
    assign quot_fix  = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !op_i[2]) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        acc_d   = '0;
                        a_d     = a_abs;
                        b_d     = b_abs;
                        div_d   = op_i[1];
                        // A zero divisor leaves the all-ones quotient un-negated.
                        neg_p_d = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (~op_i[1] | (|b_i));
                        neg_r_d = op_signed & a_i[WIDTH-1];
                    end else if (start_i && !op_i[1]) begin
                        if (op_i[0]) lo_d = a_i;
                        else         hi_d = a_i;
                    end
                end
                S_RUN: begin
                    if (div_q) begin
                        acc_d = {div_rem, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                        a_d   = a_q << 1;
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                        b_d   = b_q >> 1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) state_d = S_FIX;
                end
                S_FIX: begin
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit holding the HI/LO registers. It sits in the execute stage directly downstream of `regfile`: it consumes the `rdata1`/`rdata2` operand pair (as `a`/`b`) and runs MULT/MULTU/DIV/DIVU over multiple cycles. It also performs MTHI/MTLO writes, and exposes `hi`/`lo` for MFHI/MFLO, which return to `regfile` via writeback. `busy` feeds the hazard unit, which must stall HI/LO consumers and new muldiv ops.

## Interface
- `WIDTH`, 32: operand and HI/LO width; also the iteration count.
- Reset: `reset`, synchronous, active-high; clock `clk`.
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `a` in WIDTH: operand rs (multiplicand/dividend; MTHI/MTLO source).
- `b` in WIDTH: operand rt (multiplier/divisor).
- `flush` in 1: abort the in-flight op without touching HI/LO.
- `busy` out 1: high while an arithmetic op is in flight.
- `done` out 1: one-cycle pulse after an arithmetic op commits HI/LO.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- State machine: IDLE, RUN, FIX. `busy` = (state != IDLE).
- IDLE, `start`, arithmetic op, `flush`=0:
  - Latch |a| and |b|; magnitudes are used only for signed ops, raw values otherwise.
  - Latch the result sign bits (product sign a^b; quotient sign a^b; remainder sign a).
  - Clear the iteration counter and the 2*WIDTH accumulator; go to RUN.
- RUN, one iteration per cycle for WIDTH cycles:
  - Multiply: radix-2 shift-add on the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. A trial subtract of WIDTH+1 bits decides the quotient bit.
  - After iteration WIDTH-1, go to FIX.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - MULT*: {hi,lo} = 2*WIDTH-bit product.
  - DIV*: lo = quotient, hi = remainder.
  - Go to IDLE; `done` registered high for the following cycle.
- Divide by zero, signed or unsigned: lo = all ones, hi = original `a`. The computation still takes the full latency.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0; no exception.
- MTHI/MTLO in IDLE: hi (resp. lo) = `a` at the sampling edge. No busy, no done; the other register is unchanged.
- `start` while `busy`=1 is ignored entirely; the hazard unit guarantees this does not occur.
- Undefined ops 110/111 are ignored.
- `flush`:
  - In any state, `flush` forces IDLE at the next edge; hi/lo keep their previous values and `done` stays 0.
  - In IDLE, `flush` with `start` wins: `start` is dropped, including MTHI/MTLO.
- `reset` overrides everything: state IDLE, hi = lo = 0, busy = done = 0, accumulator cleared.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0.
- Edge E0 samples `start`. `busy` is high from after E0 through E0+WIDTH+1 (E1..EW are RUN, EW+1 is FIX), which is WIDTH+1 cycles (33 for WIDTH=32).
- hi/lo take new values at edge E0+WIDTH+1. In the same cycle `busy`=0 and `done`=1, so a stalled MFHI may issue that cycle.
- A new `start` is accepted in the cycle `busy` first reads 0, so ops run back-to-back with no bubble.
- MTHI/MTLO: hi/lo visible the cycle after the sampling edge; 1-cycle latency.
- `hi`/`lo` are direct register outputs (no combinational path from the inputs).
- Flush at edge Ef: `busy`=0 from the cycle after Ef, and `done` is never raised for the aborted op.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF. Expect busy high exactly 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, with a single done pulse.
- MULT a=0xFFFFFFFD (-3) b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000×0x80000000: hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2: lo=3, hi=1, issued back-to-back with no idle cycle between ops.
- Corners:
  - DIVU a=5 b=0: lo=0xFFFFFFFF, hi=5.
  - DIV a=0x80000000 b=0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI a=0x12345678: hi=0x12345678 next cycle, busy never asserts, lo unchanged. A `start` pulsed mid-MULT (cycle 5) is ignored and the MULT result is unaffected.
- Flush and reset:
  - MULT 3×4 after hi/lo=0xAA/0xBB, with `flush` at cycle 10: busy drops next cycle, hi/lo stay 0xAA/0xBB, no done.
  - Repeat with `reset` instead: hi=lo=0, busy=0.
